// File: rtl/dds_pkg.sv
// Shared constants and ROM generator for the multi-channel DDS.
package dds_pkg;
  localparam int PIPE_LAT = 3;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  localparam logic CFG_SEL_FTW  = 1'b0;
  localparam logic CFG_SEL_POFF = 1'b1;

  // Quarter-wave entry sampled at the bin midpoint; Taylor series keeps
  // the evaluation to plain real arithmetic at elaboration time.
  function automatic int rom_entry(input int k, input int lut_w,
                                   input int out_w);
    real x;
    real t;
    real s;
    int  amp;
    amp = (1 << (out_w - 1)) - 1;
    x = 1.5707963267948966 * (real'(k) + 0.5) / real'(1 << lut_w);
    t = x;
    s = x;
    for (int i = 1; i < 10; i++) begin
      t = -t * x * x / real'((2 * i) * (2 * i + 1));
      s = s + t;
    end
    return $rtoi(real'(amp) * s + 0.5);
  endfunction
endpackage

// File: rtl/dds_sine_rom.sv
// Quarter-wave sine ROM with a registered read port.
module dds_sine_rom import dds_pkg::*; #(
  parameter int LUT_ADDR_W = 10,
  parameter int OUT_W      = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LUT_ADDR_W-1:0] addr_i,
  output logic [OUT_W-2:0]      data_o
);
  localparam int DEPTH = 1 << LUT_ADDR_W;

  logic [OUT_W-2:0] rom_w [DEPTH];
  logic [OUT_W-2:0] data_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int V = rom_entry(k, LUT_ADDR_W, OUT_W);
    assign rom_w[k] = (OUT_W-1)'(V);
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= rom_w[addr_i];
  end

  assign data_o = data_q;
endmodule

// File: rtl/dds_multi_ch.sv
// Multi-channel DDS: shadowed tuning, phase accumulators,
// three-stage sine pipeline and a decimation strobe.
module dds_multi_ch import dds_pkg::*; #(
  parameter int NUM_CH     = 2,
  parameter int PHASE_W    = 32,
  parameter int LUT_ADDR_W = 10,
  parameter int OUT_W      = 14,
  parameter int DECIM_W    = 4,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cfg_wr,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic                    cfg_sel,
  input  logic [PHASE_W-1:0]      cfg_data,
  input  logic                    cfg_commit,
  input  logic                    cfg_phase_clr,
  input  logic [DECIM_W-1:0]      decim,
  output logic                    sample_stb,
  output logic [NUM_CH*OUT_W-1:0] dout_signed,
  output logic [NUM_CH*OUT_W-1:0] dout
);
  localparam int TOP_W = LUT_ADDR_W + 2;
  localparam int SH    = PHASE_W - TOP_W;

  logic [DECIM_W-1:0]  cnt_q, lim_q, lim;
  logic [PIPE_LAT-1:0] vld_q;

  // The period limit is sampled at the start of each period.
  assign lim = (cnt_q == '0) ? decim : lim_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      lim_q <= '0;
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[PIPE_LAT-2:0], 1'b1};
      if (en) begin
        if (cnt_q == '0) lim_q <= decim;
        cnt_q <= (cnt_q >= lim) ? '0 : cnt_q + DECIM_W'(1);
      end
    end
  end

  assign sample_stb = en && (cnt_q == '0) && vld_q[PIPE_LAT-1];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PHASE_W-1:0]    ftw_sh_q, poff_sh_q, ftw_q, poff_q, acc_q;
    logic [PHASE_W-1:0]    ph;
    logic [TOP_W-1:0]      ph_top;
    logic [1:0]            q1_q, q2_q;
    logic [LUT_ADDR_W-1:0] a1_q, addr;
    logic [OUT_W-2:0]      rom;
    logic signed [OUT_W-1:0] mag, val_d, val_q;
    logic                  wr;

    assign wr     = cfg_wr && (cfg_ch == CH_W'(c));
    assign ph     = acc_q + poff_q;
    assign ph_top = TOP_W'(ph >> SH);
    assign addr   = (q1_q == QUAD_1 || q1_q == QUAD_3) ? ~a1_q : a1_q;
    assign mag    = {1'b0, rom};
    assign val_d  = (q2_q == QUAD_2 || q2_q == QUAD_3) ? -mag : mag;

    always_ff @(posedge clk) begin
      if (rst) begin
        ftw_sh_q  <= '0;
        poff_sh_q <= '0;
        ftw_q     <= '0;
        poff_q    <= '0;
        acc_q     <= '0;
        q1_q      <= QUAD_0;
        a1_q      <= '0;
        q2_q      <= QUAD_0;
        val_q     <= '0;
      end else begin
        if (wr && cfg_sel == CFG_SEL_FTW)  ftw_sh_q  <= cfg_data;
        if (wr && cfg_sel == CFG_SEL_POFF) poff_sh_q <= cfg_data;
        if (cfg_commit) begin
          ftw_q  <= ftw_sh_q;
          poff_q <= poff_sh_q;
        end
        if (cfg_phase_clr) acc_q <= '0;
        else if (en)       acc_q <= acc_q + ftw_q;
        q1_q  <= ph_top[TOP_W-1 -: 2];
        a1_q  <= ph_top[LUT_ADDR_W-1:0];
        q2_q  <= q1_q;
        val_q <= val_d;
      end
    end

    dds_sine_rom #(
      .LUT_ADDR_W(LUT_ADDR_W),
      .OUT_W     (OUT_W)
    ) u_rom (
      .clk   (clk),
      .rst   (rst),
      .addr_i(addr),
      .data_o(rom)
    );

    assign dout_signed[c*OUT_W +: OUT_W] = val_q;
    assign dout[c*OUT_W +: OUT_W] =
      {~val_q[OUT_W-1], val_q[OUT_W-2:0]};
  end
endmodule

// File: tb/tb_dds_multi_ch.sv
// Scoreboard bench for dds_multi_ch against a behavioural tone model.
module tb_dds_multi_ch;
  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
  localparam real PI    = 3.14159265358979323846;
  localparam logic [27:0] MSBS = {14'h2000, 14'h2000};

  logic        clk = 1'b0;
  logic        rst, en, cfg_wr, cfg_sel, cfg_commit, cfg_phase_clr;
  logic [CH_W-1:0] cfg_ch;
  logic [31:0] cfg_data;
  logic [3:0]  decim;
  logic        sample_stb;
  logic [27:0] dout_signed, dout;

  dds_multi_ch #(
    .NUM_CH(2), .PHASE_W(32), .LUT_ADDR_W(10),
    .OUT_W(14), .DECIM_W(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_wr       (cfg_wr),
    .cfg_ch       (cfg_ch),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .cfg_commit   (cfg_commit),
    .cfg_phase_clr(cfg_phase_clr),
    .decim        (decim),
    .sample_stb   (sample_stb),
    .dout_signed  (dout_signed),
    .dout         (dout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int unsigned m_ftw_sh[NUM_CH], m_poff_sh[NUM_CH];
  int unsigned m_ftw[NUM_CH], m_poff[NUM_CH], m_acc[NUM_CH];
  int unsigned hist[NUM_CH][$];
  int          m_k, m_pos, m_len;
  bit          exp_ok, exp_stb, started;
  logic [27:0] exp_now;
  logic [27:0] sb[$];

  // Ideal tone: sine sampled at the midpoint of the 4096-bin phase cell.
  function automatic int sine_of(input int unsigned ph);
    real v;
    int  m;
    v = 8191.0 * $sin(2.0 * PI * (real'(ph >> 20) + 0.5) / 4096.0);
    m = $rtoi(((v < 0.0) ? -v : v) + 0.5);
    return (v < 0.0) ? -m : m;
  endfunction

  function automatic logic [27:0] pack(input int unsigned p0,
                                       input int unsigned p1);
    logic [13:0] a, b;
    a = 14'(sine_of(p0));
    b = 14'(sine_of(p1));
    return {b, a};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_ftw_sh[c] = 0; m_poff_sh[c] = 0;
      m_ftw[c] = 0; m_poff[c] = 0; m_acc[c] = 0;
      hist[c].delete();
    end
    m_k = 0; m_pos = 0; m_len = 1;
  endtask

  task automatic model_cycle();
    int unsigned nf[NUM_CH], np[NUM_CH];
    started = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      hist[c].push_back(m_acc[c] + m_poff[c]);
      if (hist[c].size() > 4) void'(hist[c].pop_front());
    end
    exp_ok  = (m_k >= 3);
    exp_now = exp_ok ? pack(hist[0][0], hist[1][0]) : '0;
    exp_stb = en && (m_pos == 0) && exp_ok;
    if (exp_stb) sb.push_back(exp_now);
    if (rst) begin
      model_reset();
      return;
    end
    m_k++;
    for (int c = 0; c < NUM_CH; c++) begin
      nf[c] = cfg_commit ? m_ftw_sh[c] : m_ftw[c];
      np[c] = cfg_commit ? m_poff_sh[c] : m_poff[c];
      if (cfg_phase_clr) m_acc[c] = 0;
      else if (en)       m_acc[c] = m_acc[c] + m_ftw[c];
      m_ftw[c]  = nf[c];
      m_poff[c] = np[c];
    end
    if (cfg_wr) begin
      if (cfg_sel) m_poff_sh[cfg_ch] = cfg_data;
      else         m_ftw_sh[cfg_ch]  = cfg_data;
    end
    if (en) begin
      if (m_pos == 0) m_len = int'(decim) + 1;
      m_pos++;
      if (m_pos >= m_len) m_pos = 0;
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      total++;
      if (sample_stb !== exp_stb) begin
        bad++;
        $display("FAIL stb: got %b want %b at %0t",
                 sample_stb, exp_stb, $time);
      end
      if (sample_stb === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_empty: strobe with nothing expected at %0t",
                   $time);
        end else begin
          logic [27:0] e;
          e = sb.pop_front();
          if (dout_signed !== e || dout !== (e ^ MSBS)) begin
            bad++;
            $display("FAIL sample: got s=%h u=%h want s=%h u=%h at %0t",
                     dout_signed, dout, e, e ^ MSBS, $time);
          end
        end
      end
    end
  end

  task automatic cyc();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_rst();
    model_cycle();
    @(negedge clk);
    total++;
    if (dout_signed !== 28'h0 || dout !== MSBS || sample_stb !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: got s=%h u=%h stb=%b want 0 %h 0",
               dout_signed, dout, sample_stb, MSBS);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_chk(input int e0, input int e1, input logic [13:0] u0);
    logic [13:0] w0, w1;
    w0 = 14'(e0);
    w1 = 14'(e1);
    model_cycle();
    @(negedge clk);
    total++;
    if (dout_signed !== {w1, w0} || dout[13:0] !== u0) begin
      bad++;
      $display("FAIL tone: got s=%h u0=%h want ch0=%0d ch1=%0d u0=%h",
               dout_signed, dout[13:0], e0, e1, u0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_model();
    model_cycle();
    @(negedge clk);
    total++;
    if (!exp_ok || dout_signed !== exp_now) begin
      bad++;
      $display("FAIL held: got s=%h want %h (ok=%b)",
               dout_signed, exp_now, exp_ok);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; cfg_wr = 0; cfg_commit = 0; cfg_phase_clr = 0;
    cfg_sel = 0; cfg_ch = '0; cfg_data = '0;
  endtask

  task automatic wr(input int ch, input logic sel, input logic [31:0] d);
    cfg_wr = 1; cfg_ch = CH_W'(ch); cfg_sel = sel; cfg_data = d;
    cyc();
    cfg_wr = 0;
  endtask

  initial begin
    started = 0;
    exp_stb = 0;
    model_reset();
    idle();
    en = 1; decim = 0; rst = 1;
    cyc();
    rst = 0;
    cyc_rst();
    repeat (5) cyc();

    wr(0, 1'b0, 32'h4000_0000);
    wr(1, 1'b0, 32'h4000_0000);
    wr(1, 1'b1, 32'h4000_0000);
    cfg_commit = 1; cyc(); cfg_commit = 0;
    cfg_phase_clr = 1; cyc(); cfg_phase_clr = 0;
    repeat (3) cyc();
    cyc_chk(6, 8191, 14'h2006);
    cyc_chk(8191, -6, 14'h3FFF);
    cyc_chk(-6, -8191, 14'h1FFA);
    cyc_chk(-8191, 6, 14'h0001);

    wr(0, 1'b0, 32'h8000_0000);
    cfg_commit = 1; cfg_phase_clr = 1; cyc();
    cfg_commit = 0; cfg_phase_clr = 0;
    repeat (3) cyc();
    cyc_chk(6, 8191, 14'h2006);
    cyc_chk(-6, -6, 14'h1FFA);
    cyc_chk(6, -8191, 14'h2006);

    decim = 3;
    repeat (12) cyc();
    for (int i = 0; i < 8 && m_pos != 2; i++) cyc();
    decim = 1;
    repeat (10) cyc();
    en = 0;
    repeat (4) cyc();
    cyc_model();
    en = 1; decim = 0;
    repeat (4) cyc();

    rst = 1; cyc();
    rst = 0; cyc_rst();

    for (int i = 0; i < 3000; i++) begin
      idle();
      rst = ($urandom_range(0, 499) == 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        cfg_wr = 1;
        cfg_ch = CH_W'($urandom_range(0, 1));
        cfg_sel = 1'($urandom_range(0, 1));
        cfg_data = $urandom;
      end
      cfg_commit = ($urandom_range(0, 15) == 0);
      cfg_phase_clr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 31) == 0) decim = 4'($urandom_range(0, 5));
      cyc();
    end
    idle();
    en = 1;
    repeat (5) cyc();

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d expected samples never strobed",
               sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
